// File: rtl/data_memory_sized_pkg.sv
// Shared types for the sized data memory: access-size codes, clear sequencer
// states and a byte-count helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        MS_B,
        MS_H,
        MS_W,
        MS_D
    } mem_size_e;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE_WAIT,
        RUN
    } dmem_state_e;

    function automatic logic [3:0] size_bytes(mem_size_e s);
        return 4'd1 << s;
    endfunction

endpackage

// File: rtl/data_memory_sized_load_extend.sv
// Extracts the low 2^size bytes of a raw little-endian word and sign- or
// zero-extends them to XLEN. Also used by the MEM-stage forwarding path.
module load_extend
    import dmem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] raw,
    input  logic [1:0]      size,
    input  logic            load_unsigned,
    output logic [XLEN-1:0] result
);

    int              nbits;
    int              shamt;
    logic [XLEN-1:0] shifted;

    // Left-justify the field, then shift back logically or arithmetically.
    always_comb begin
        nbits   = 8 * int'(size_bytes(mem_size_e'(size)));
        shamt   = (nbits >= XLEN) ? 0 : (XLEN - nbits);
        shifted = raw << shamt;
        if (load_unsigned) begin
            result = shifted >> shamt;
        end else begin
            result = $signed(shifted) >>> shamt;
        end
    end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed MEM-stage data memory with sized loads/stores, registered
// read, access fault reporting, reset-driven clear and a debug read port.
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int DEPTH_BYTES    = 64,
    parameter int CLEAR_ON_RESET = 1,
    parameter int DBG_IDX_W      = $clog2(DEPTH_BYTES / (XLEN / 8))
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 memoryread,
    input  logic                 memorywrite,
    input  logic [1:0]           size,
    input  logic                 load_unsigned,
    input  logic [XLEN-1:0]      address,
    input  logic [XLEN-1:0]      write_data,
    output logic [XLEN-1:0]      read_data,
    output logic                 read_valid,
    output logic                 fault,
    output logic                 fault_oob,
    output logic                 ready,
    input  logic [DBG_IDX_W-1:0] dbg_idx,
    output logic [XLEN-1:0]      dbg_data
);

    localparam int WB     = XLEN / 8;
    localparam int LB     = $clog2(WB);
    localparam int AW     = $clog2(DEPTH_BYTES);
    localparam int NWORDS = DEPTH_BYTES / WB;

    logic [7:0] mem [DEPTH_BYTES];

    dmem_state_e          state_reg;
    logic [DBG_IDX_W-1:0] clr_ptr_reg;
    logic                 ready_reg;
    logic                 read_valid_reg;
    logic                 fault_reg;
    logic                 fault_oob_reg;
    logic [XLEN-1:0]      read_data_reg;

    logic [3:0]      nbytes;
    logic [XLEN:0]   end_addr;
    logic            is_oob;
    logic            is_mis;
    logic            illegal;
    logic            bad_req;
    logic            do_load;
    logic            do_store;
    logic [AW-1:0]   addr_idx;
    logic [XLEN-1:0] raw_word;
    logic [XLEN-1:0] ext_word;

    // One extra bit on the end address so ranges near the top of the address
    // space cannot wrap around and look legal.
    always_comb begin
        nbytes   = size_bytes(mem_size_e'(size));
        end_addr = {1'b0, address} + (XLEN + 1)'(nbytes);
        is_oob   = end_addr > (XLEN + 1)'(DEPTH_BYTES);
        is_mis   = (|(address[2:0] & (nbytes[2:0] - 3'd1))) || ((XLEN == 32) && (size == 2'd3));
        illegal  = is_oob || is_mis;
        bad_req  = ready_reg && !reset && (memoryread || memorywrite) && illegal;
        do_load  = ready_reg && !reset && memoryread && !illegal;
        do_store = ready_reg && !reset && memorywrite && !illegal;
        addr_idx = address[AW-1:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < WB; gi++) begin : g_lane
            assign raw_word[8*gi +: 8] = mem[AW'(addr_idx + AW'(gi))];
            assign dbg_data[8*gi +: 8] = mem[{dbg_idx, LB'(gi)}];
        end
    endgenerate

    load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .raw          (raw_word),
        .size         (size),
        .load_unsigned(load_unsigned),
        .result       (ext_word)
    );

    // The load captures raw_word from the pre-edge array, so a simultaneous
    // store to overlapping bytes is naturally read-before-write.
    always_ff @(posedge clk) begin
        if (!reset && (state_reg == CLEAR)) begin
            for (int i = 0; i < WB; i++) begin
                mem[{clr_ptr_reg, LB'(i)}] <= 8'h00;
            end
        end else if (do_store) begin
            for (int i = 0; i < WB; i++) begin
                if (i < int'(nbytes)) begin
                    mem[AW'(addr_idx + AW'(i))] <= write_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE_WAIT;
            clr_ptr_reg    <= '0;
            ready_reg      <= 1'b0;
            read_data_reg  <= '0;
            read_valid_reg <= 1'b0;
            fault_reg      <= 1'b0;
            fault_oob_reg  <= 1'b0;
        end else begin
            read_valid_reg <= do_load;
            fault_reg      <= bad_req;
            fault_oob_reg  <= bad_req && is_oob;
            if (do_load) begin
                read_data_reg <= ext_word;
            end
            case (state_reg)
                CLEAR: begin
                    clr_ptr_reg <= clr_ptr_reg + 1'b1;
                    if (clr_ptr_reg == DBG_IDX_W'(NWORDS - 1)) begin
                        state_reg <= RUN;
                        ready_reg <= 1'b1;
                    end
                end
                IDLE_WAIT: begin
                    state_reg <= RUN;
                    ready_reg <= 1'b1;
                end
                RUN: begin
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE_WAIT;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign read_data  = read_data_reg;
    assign read_valid = read_valid_reg;
    assign fault      = fault_reg;
    assign fault_oob  = fault_oob_reg;
    assign ready      = ready_reg;

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: stimulus pushes expected load/fault
// responses, a negedge monitor pops and compares them as the DUT pulses.
module tb_data_memory_sized;

    localparam int XLEN  = 64;
    localparam int DEPTH = 64;
    localparam int DW    = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            memoryread = 1'b0;
    logic            memorywrite = 1'b0;
    logic [1:0]      size = 2'd0;
    logic            load_unsigned = 1'b0;
    logic [XLEN-1:0] address = '0;
    logic [XLEN-1:0] write_data = '0;
    logic [XLEN-1:0] read_data;
    logic            read_valid;
    logic            fault;
    logic            fault_oob;
    logic            ready;
    logic [DW-1:0]   dbg_idx = '0;
    logic [XLEN-1:0] dbg_data;

    data_memory_sized #(
        .XLEN          (XLEN),
        .DEPTH_BYTES   (DEPTH),
        .CLEAR_ON_RESET(1),
        .DBG_IDX_W     (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .memoryread   (memoryread),
        .memorywrite  (memorywrite),
        .size         (size),
        .load_unsigned(load_unsigned),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .fault        (fault),
        .fault_oob    (fault_oob),
        .ready        (ready),
        .dbg_idx      (dbg_idx),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_fault;
        bit          oob;
        logic [63:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [63:0] last_data = '0;
    logic [63:0] table_vals [8] = '{64'd15, 64'd2, 64'd1, 64'd44, 64'd100, 64'd6, 64'd7, 64'd8};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every read_valid or fault pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (read_valid === 1'b1 || fault === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: read_valid=%0b fault=%0b, expected no pulse", read_valid, fault);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("[TB] %s rv=%0b fault=%0b oob=%0b data=0x%h", e.name, read_valid, fault, fault_oob, read_data);
                check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
                check({e.name, "_fault"}, 64'(fault), 64'(e.is_fault));
                check({e.name, "_valid"}, 64'(read_valid), 64'(!e.is_fault));
                if (e.is_fault) check({e.name, "_oob"}, 64'(fault_oob), 64'(e.oob));
                check({e.name, "_data"}, read_data, e.data);
            end
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [63:0] addr, input logic [63:0] wd, input string name,
                          input bit exp_fault, input bit exp_oob, input logic [63:0] exp_data);
        exp_t e;
        memoryread    = rd;
        memorywrite   = wr;
        size          = sz;
        load_unsigned = uns;
        address       = addr;
        write_data    = wd;
        @(posedge clk);
        #1;
        e.cyc  = cyc;
        e.name = name;
        if (exp_fault) begin
            e.is_fault = 1'b1;
            e.oob      = exp_oob;
            e.data     = last_data;
            sb_q.push_back(e);
        end else if (rd) begin
            e.is_fault = 1'b0;
            e.oob      = 1'b0;
            e.data     = exp_data;
            last_data  = exp_data;
            sb_q.push_back(e);
        end else begin
            $display("[TB] %s store issued addr=%0d data=0x%h", name, addr, wd);
        end
        memoryread  = 1'b0;
        memorywrite = 1'b0;
    endtask

    task automatic dbg_check(input int idx, input logic [63:0] exp);
        dbg_idx = DW'(idx);
        #1;
        $display("[TB] dbg[%0d] = 0x%h", idx, dbg_data);
        check($sformatf("dbg%0d", idx), dbg_data, exp);
    endtask

    // Counts clock edges after reset release; ready must rise on exactly the 8th.
    task automatic poll_ready(input string tag, input bit with_reqs);
        for (int k = 1; k <= 8; k++) begin
            if (with_reqs) begin
                memoryread  = 1'b1;
                memorywrite = 1'b1;
                size        = 2'd3;
                address     = 64'd0;
                write_data  = '1;
            end
            @(posedge clk);
            #1;
            check($sformatf("%s_ready_c%0d", tag, k), 64'(ready), 64'(k == 8));
        end
        memoryread  = 1'b0;
        memorywrite = 1'b0;
        $display("[TB] %s ready observed after clear", tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_valid", 64'(read_valid), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_oob", 64'(fault_oob), 64'd0);
        check("rst_data", read_data, 64'd0);
        $display("[TB] reset state sampled");
        reset = 1'b0;
        poll_ready("clr1", 1'b0);
        for (int i = 0; i < 8; i++) dbg_check(i, 64'd0);

        // Reset pulsed mid-clear restarts the sequence; requests meanwhile ignored.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        poll_ready("clr2", 1'b1);
        for (int i = 0; i < 8; i++) dbg_check(i, 64'd0);

        access(0, 1, 2'd3, 0, 64'd0, 64'h8877665544332211, "sd0", 0, 0, 64'd0);
        access(1, 0, 2'd0, 0, 64'd7, 64'd0, "lb7", 0, 0, 64'hFFFF_FFFF_FFFF_FF88);
        access(1, 0, 2'd0, 1, 64'd7, 64'd0, "lbu7", 0, 0, 64'h88);
        access(1, 0, 2'd1, 0, 64'd2, 64'd0, "lh2", 0, 0, 64'h4433);
        access(1, 0, 2'd2, 0, 64'd4, 64'd0, "lw4", 0, 0, 64'hFFFF_FFFF_8877_6655);
        access(1, 1, 2'd2, 0, 64'd12, 64'hDEADBEEF, "sw_lw12", 0, 0, 64'd0);
        access(1, 0, 2'd3, 0, 64'd8, 64'd0, "ld8", 0, 0, 64'hDEADBEEF_0000_0000);
        access(1, 0, 2'd1, 0, 64'd3, 64'd0, "lh3_mis", 1, 0, 64'd0);
        access(0, 1, 2'd3, 0, 64'd60, 64'h1234_5678, "sd60_oob", 1, 1, 64'd0);
        dbg_check(7, 64'd0);
        access(1, 0, 2'd3, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, "ld_wrap", 1, 1, 64'd0);
        access(1, 0, 2'd1, 0, 64'd63, 64'd0, "lh63_both", 1, 1, 64'd0);
        access(1, 0, 2'd0, 1, 64'd63, 64'd0, "lbu63", 0, 0, 64'd0);
        access(1, 1, 2'd1, 0, 64'd17, 64'hBEEF, "rw_mis17", 1, 0, 64'd0);
        dbg_check(2, 64'd0);

        for (int i = 0; i < 8; i++)
            access(0, 1, 2'd3, 0, 64'(8 * i), table_vals[i], $sformatf("sd_tab%0d", i), 0, 0, 64'd0);
        for (int i = 0; i < 8; i++) dbg_check(i, table_vals[i]);
        access(0, 1, 2'd0, 0, 64'd40, 64'h05, "sb40", 0, 0, 64'd0);
        for (int i = 0; i < 8; i++) dbg_check(i, (i == 5) ? 64'h05 : table_vals[i]);
        access(1, 0, 2'd0, 1, 64'd40, 64'd0, "lbu40", 0, 0, 64'h05);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
